// File: rtl/io_latch_pkg.sv
// Shared types and helpers for the Z80 I/O latch sequencer.
// FSM encoding, strobe idle levels and select-width helper.
package io_latch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_STROBE,
        HOLD,
        RD_DRIVE,
        IGNORE
    } state_t;

    localparam logic LE_OFF = 1'b0;
    localparam logic OE_OFF = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_latch_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous Z80 strobes.
// Resets to the inactive (high) level.
module io_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_latch_ctrl.sv
// Z80 I/O-cycle sequencer driving latch-bank LE/OE strobes and WAIT.
// Wait-state generation is built only when IO_LATCH_WAIT_EN is defined.
module io_latch_ctrl
    import io_latch_pkg::*;
#(
    parameter int         NUM_PORTS   = 4,
    parameter logic [7:0] BASE_ADDR   = 8'h40,
    parameter int         WAIT_CYCLES = 2,
    parameter int         LE_PULSE    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_H,
    input  logic [7:0]           ADDR,
    input  logic                 IORQ_L,
    input  logic                 RD_L,
    input  logic                 WR_L,
    input  logic                 M1_L,
    output logic [NUM_PORTS-1:0] LE_H,
    output logic [NUM_PORTS-1:0] OE_L,
    output logic                 WAIT_L,
    output logic                 BUS_DIR_H,
    output logic                 ERR_H
);

    localparam int SW = sel_width(NUM_PORTS);
`ifdef IO_LATCH_WAIT_EN
    localparam int WC = WAIT_CYCLES;
`else
    // No wait states: writes strobe straight away.
    localparam int WC = WAIT_CYCLES * 0;
`endif
    localparam logic [3:0] WR_LAST = 4'(WC > 0 ? WC - 1 : 0);
    localparam logic [3:0] LE_LAST = 4'(LE_PULSE - 1);

    logic iorq_l_s, rd_l_s, wr_l_s, m1_l_s;

    io_sync2 u_sync_iorq (.clk(CLK), .rst(RESET_H), .d(IORQ_L), .q(iorq_l_s));
    io_sync2 u_sync_rd   (.clk(CLK), .rst(RESET_H), .d(RD_L),   .q(rd_l_s));
    io_sync2 u_sync_wr   (.clk(CLK), .rst(RESET_H), .d(WR_L),   .q(wr_l_s));
    io_sync2 u_sync_m1   (.clk(CLK), .rst(RESET_H), .d(M1_L),   .q(m1_l_s));

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [SW-1:0]   sel_q;
    logic            err_pend, err_pend_nx;

    logic            req, hit, rd_exit, rd_stay;
    logic [SW-1:0]   sel_d;

    assign req     = !iorq_l_s && m1_l_s;
    assign hit     = ({1'b0, ADDR} >= 9'(BASE_ADDR)) &&
                     ({1'b0, ADDR} <  9'(int'(BASE_ADDR) + NUM_PORTS));
    assign sel_d   = SW'(ADDR - BASE_ADDR);
    assign rd_exit = iorq_l_s || rd_l_s;
    assign rd_stay = (state == RD_DRIVE) && !rd_exit;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        err_pend_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx = '0;
                    if (!rd_l_s && !wr_l_s) begin
                        err_pend_nx = 1'b1;
                        state_nx    = IGNORE;
                    end else if (!wr_l_s && hit) begin
                        state_nx = (WC == 0) ? WR_STROBE : WR_WAIT;
                    end else if (!rd_l_s && hit) begin
                        state_nx = RD_DRIVE;
                    end else begin
                        state_nx = IGNORE;
                    end
                end
            end
            WR_WAIT: begin
                if (cnt == WR_LAST) begin
                    state_nx = WR_STROBE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            WR_STROBE: begin
                // An early IORQ release skips HOLD once the pulse is done.
                if (cnt == LE_LAST) begin
                    state_nx = iorq_l_s ? IDLE : HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            RD_DRIVE: begin
                if (rd_exit) begin
                    state_nx = IDLE;
                end else if (cnt != 4'hf) begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            HOLD, IGNORE: begin
                if (iorq_l_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    logic [NUM_PORTS-1:0] le_d, oe_d;
    logic                 wait_d;

    always_comb begin
        le_d = {NUM_PORTS{LE_OFF}};
        oe_d = {NUM_PORTS{OE_OFF}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q == SW'(i)) begin
                le_d[i] = (state == WR_STROBE);
                oe_d[i] = !rd_stay;
            end
        end
`ifdef IO_LATCH_WAIT_EN
        wait_d = !((state == WR_WAIT) || (state == WR_STROBE) ||
                   (rd_stay && (cnt < 4'(WC))));
`else
        wait_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK or posedge RESET_H) begin
        if (RESET_H) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_q     <= '0;
            err_pend  <= 1'b0;
            LE_H      <= {NUM_PORTS{LE_OFF}};
            OE_L      <= {NUM_PORTS{OE_OFF}};
            WAIT_L    <= 1'b1;
            BUS_DIR_H <= 1'b0;
            ERR_H     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            err_pend  <= err_pend_nx;
            if (state == IDLE && req) begin
                sel_q <= sel_d;
            end
            LE_H      <= le_d;
            OE_L      <= oe_d;
            WAIT_L    <= wait_d;
            BUS_DIR_H <= rd_stay;
            ERR_H     <= err_pend;
        end
    end

endmodule

// File: tb/tb_io_latch_ctrl.sv
// Self-checking bench for io_latch_ctrl with a cycle-window model.
// Follows IO_LATCH_WAIT_EN the same way the design does.
module tb_io_latch_ctrl;

    localparam int NP  = 4;
    localparam int WCY = 2;
    localparam int LEP = 1;
`ifdef IO_LATCH_WAIT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif
    localparam int WC = WEN ? WCY : 0;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_ERR  = 3;

    logic          CLK = 1'b0;
    logic          RESET_H = 1'b1;
    logic [7:0]    ADDR = 8'h00;
    logic          IORQ_L = 1'b1;
    logic          RD_L = 1'b1;
    logic          WR_L = 1'b1;
    logic          M1_L = 1'b1;
    logic [NP-1:0] LE_H;
    logic [NP-1:0] OE_L;
    logic          WAIT_L;
    logic          BUS_DIR_H;
    logic          ERR_H;

    io_latch_ctrl #(
        .NUM_PORTS(NP), .BASE_ADDR(8'h40),
        .WAIT_CYCLES(WCY), .LE_PULSE(LEP)
    ) dut (
        .CLK(CLK), .RESET_H(RESET_H), .ADDR(ADDR),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L),
        .LE_H(LE_H), .OE_L(OE_L), .WAIT_L(WAIT_L),
        .BUS_DIR_H(BUS_DIR_H), .ERR_H(ERR_H)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Current transaction: kind, detection edge, bank, last active read cycle.
    int m_kind = K_NONE;
    int m_d    = 0;
    int m_sel  = 0;
    int m_end  = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] model_out(input int c);
        logic [NP-1:0] le = '0;
        logic [NP-1:0] oe = '1;
        logic w = 1'b1;
        logic dir = 1'b0;
        logic err = 1'b0;
        int k = c - m_d;
        case (m_kind)
            K_WR: begin
                if (k >= 1 && k <= WC + LEP) w = !WEN;
                if (k >= WC + 1 && k <= WC + LEP) le[m_sel] = 1'b1;
            end
            K_RD: begin
                if (k >= 1 && c <= m_end) begin
                    oe[m_sel] = 1'b0;
                    dir = 1'b1;
                    if (k <= WC) w = 1'b0;
                end
            end
            K_ERR: if (k == 1) err = 1'b1;
            default: ;
        endcase
        return {le, oe, w, dir, err};
    endfunction

    always @(posedge CLK) begin
        #3;
        check("cycle outputs {le,oe,wait,dir,err}",
              32'({LE_H, OE_L, WAIT_L, BUS_DIR_H, ERR_H}),
              32'(model_out(cyc)));
    end

    // Raw strobes change on the falling edge; detection is three edges later.
    task automatic go(input logic [7:0] a, input logic rd_l,
                      input logic wr_l, input logic m1_l, input int kind);
        @(negedge CLK);
        ADDR   = a;
        RD_L   = rd_l;
        WR_L   = wr_l;
        M1_L   = m1_l;
        IORQ_L = 1'b0;
        m_kind = kind;
        m_d    = cyc + 3;
        m_sel  = int'(a) - 'h40;
        m_end  = 32'h3fff_ffff;
    endtask

    task automatic finish_cyc(input int hold, input int gap);
        repeat (hold) @(negedge CLK);
        IORQ_L = 1'b1;
        RD_L   = 1'b1;
        WR_L   = 1'b1;
        M1_L   = 1'b1;
        m_end  = cyc + 2;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic wait_until(input int target);
        do begin
            @(posedge CLK);
            #1;
        end while (cyc < target);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset le/oe/wait/dir/err",
              32'({LE_H, OE_L, WAIT_L, BUS_DIR_H, ERR_H}),
              32'({4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0}));
        RESET_H = 1'b0;
        repeat (4) @(negedge CLK);

        go(8'h42, 1'b1, 1'b0, 1'b1, K_WR);
        wait_until(m_d + WC + 1);
        check("write 42 le", 32'(LE_H), 32'(4'b0100));
        check("write 42 wait", 32'(WAIT_L), 32'(!WEN));
        finish_cyc(4, 6);

        go(8'h41, 1'b0, 1'b1, 1'b1, K_RD);
        wait_until(m_d + 1);
        check("read 41 oe", 32'(OE_L), 32'(4'b1101));
        check("read 41 dir", 32'(BUS_DIR_H), 32'(1'b1));
        check("read 41 wait", 32'(WAIT_L), 32'(!WEN));
        finish_cyc(4, 6);

        go(8'h44, 1'b1, 1'b0, 1'b1, K_NONE);
        finish_cyc(8, 6);

        go(8'h40, 1'b0, 1'b1, 1'b0, K_NONE);
        finish_cyc(8, 6);

        go(8'h40, 1'b0, 1'b0, 1'b1, K_ERR);
        wait_until(m_d + 1);
        check("err pulse", 32'({ERR_H, LE_H, OE_L}),
              32'({1'b1, 4'b0000, 4'b1111}));
        finish_cyc(3, 6);

        go(8'h43, 1'b1, 1'b0, 1'b1, K_WR);
        wait_until(m_d + WC + 1);
        check("le before reset", 32'(LE_H), 32'(4'b1000));
        #1;
        RESET_H = 1'b1;
        IORQ_L  = 1'b1;
        RD_L    = 1'b1;
        WR_L    = 1'b1;
        M1_L    = 1'b1;
        m_kind  = K_NONE;
        #1;
        check("async reset mid-strobe",
              32'({LE_H, OE_L, WAIT_L, BUS_DIR_H}),
              32'({4'b0000, 4'b1111, 1'b1, 1'b0}));
        #1;
        RESET_H = 1'b0;
        repeat (4) @(negedge CLK);

        go(8'h43, 1'b1, 1'b0, 1'b1, K_WR);
        wait_until(m_d + WC + 1);
        check("write 43 after reset", 32'(LE_H), 32'(4'b1000));
        finish_cyc(4, 6);

        go(8'h40, 1'b0, 1'b1, 1'b1, K_RD);
        finish_cyc(7, 6);

        go(8'h40, 1'b1, 1'b0, 1'b1, K_WR);
        wait_until(m_d + WC + 1);
        check("write 40 le", 32'(LE_H), 32'(4'b0001));
        finish_cyc(4, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_latch_ctrl.md
# io_latch_ctrl

Z80 I/O-cycle sequencer for the IO board CPLD. It decodes I/O port addresses and drives the latch-enable and output-enable strobes of up to NUM_PORTS 4-bit transparent latch banks. It inserts Z80 wait states so latches capture stable data, and controls the data-bus transceiver direction during reads. It sits between the Z80 control bus and the latch banks.

## Interface
- NUM_PORTS, 4: number of latch banks served (1..8); select width SW = clog2(NUM_PORTS), minimum 1.
- BASE_ADDR, 8'h40: I/O address of port 0; port i at BASE_ADDR+i.
- WAIT_CYCLES, 2: CLK cycles WAIT_L held low before strobe/data-valid (0..15).
- LE_PULSE, 1: LE_H high width in CLK cycles (1..4).
- CLK  in  1  system clock, rising edge.
- RESET_H  in  1  asynchronous, active-high reset.
- ADDR  in  8  Z80 A[7:0].
- IORQ_L, RD_L, WR_L, M1_L  in  1 each  Z80 control strobes, asynchronous to CLK.
- LE_H  out  NUM_PORTS  per-bank latch enable, active high.
- OE_L  out  NUM_PORTS  per-bank output enable, active low.
- WAIT_L  out  1  Z80 wait request, active low.
- BUS_DIR_H  out  1  1 = transceiver drives the CPU bus (read).
- ERR_H  out  1  one-cycle pulse on a malformed cycle.

## Operation
- IORQ_L, RD_L, WR_L and M1_L pass through 2-flop synchronizers; the FSM uses only synchronized copies (suffix _s).
- Request is detected in IDLE when IORQ_L_s=0 and M1_L_s=1. Edge of detection = cycle 0.
- ADDR is registered at cycle 0. hit = BASE_ADDR <= ADDR < BASE_ADDR+NUM_PORTS. sel = ADDR-BASE_ADDR, truncated to SW bits.
- FSM states and transitions:
  - IDLE: on a request, go to WR_WAIT (WR_L_s=0, RD_L_s=1, hit), RD_DRIVE (RD_L_s=0, WR_L_s=1, hit) or IGNORE (otherwise).
  - WR_WAIT: count WAIT_CYCLES, then go to WR_STROBE.
  - WR_STROBE: LE_H[sel]=1 for LE_PULSE cycles, then go to HOLD.
  - RD_DRIVE: stay until IORQ_L_s=1 or RD_L_s=1, then go to IDLE.
  - HOLD and IGNORE: stay until IORQ_L_s=1, then go to IDLE.
- WAIT_L is low from cycle 1 through the end of WR_STROBE for writes, and for cycles 1..WAIT_CYCLES of RD_DRIVE for reads.
- In RD_DRIVE, OE_L[sel]=0 and BUS_DIR_H=1 for the whole state.
- Both RD_L_s and WR_L_s low at detection: ERR_H pulses for one cycle in cycle 1, then go to IGNORE.
- IORQ_L with M1_L low (interrupt acknowledge) is never a request.
- At most one LE_H bit and at most one OE_L bit are active at any time. LE_H and OE_L are never active together.
- WAIT_CYCLES=0: WR_WAIT lasts 0 cycles, and read WAIT_L never asserts.

## Timing
- All outputs are registered.
- Reset values: LE_H=0, OE_L=all 1s, WAIT_L=1, BUS_DIR_H=0, ERR_H=0, FSM=IDLE, synchronizers=1.
- RESET_H forces the reset values immediately, without a clock, including mid-strobe or mid-read.
- Latency from a raw strobe edge to detection is 2–3 CLK edges.
- Write timeline: WAIT_L low in cycles 1..WAIT_CYCLES+LE_PULSE; LE_H[sel] high in cycles WAIT_CYCLES+1..WAIT_CYCLES+LE_PULSE.
- Read timeline: OE_L/BUS_DIR_H active from cycle 1, and released one cycle after IORQ_L_s or RD_L_s rises.
- If IORQ_L_s rises during WR_WAIT or WR_STROBE, the strobe sequence still completes, then the FSM returns to IDLE directly.
- No new request is accepted until IDLE is re-entered.

## Configuration
- IO_LATCH_WAIT_EN defined: wait-state generation as described above.
- IO_LATCH_WAIT_EN undefined:
  - WAIT_L is constant 1 and WAIT_CYCLES is ignored (treated as 0).
  - LE_H is asserted in cycle 1.

## Structure
- Shared package io_latch_pkg holds:
  - FSM state encodings: IDLE, WR_WAIT, WR_STROBE, HOLD, RD_DRIVE, IGNORE.
  - Inactive-level constants for LE_H and OE_L.
  - The select-width function.
- Sub-module io_sync2: 2-flop synchronizer, instantiated four times.

## Test plan
- Write to 8'h42, default parameters → WAIT_L low in cycles 1–3; LE_H=4'b0100 in cycle 3 only; OE_L=4'b1111 throughout.
- Read from 8'h41 → OE_L=4'b1101 and BUS_DIR_H=1 from cycle 1 until one cycle after IORQ_L_s rises; WAIT_L low in cycles 1–2.
- Address 8'h44, and separately IORQ_L=0 with M1_L=0 → no LE/OE/WAIT activity; FSM returns to IDLE after IORQ_L rises.
- RD_L and WR_L both low at 8'h40 → ERR_H=1 in cycle 1 only; no strobes.
- RESET_H pulsed during an LE_H pulse → LE_H=0 and WAIT_L=1 before the next CLK edge; a following write to 8'h43 sequences normally.
- Built without IO_LATCH_WAIT_EN, write to 8'h40 → WAIT_L stays 1; LE_H=4'b0001 in cycle 1 only.
